// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: memory widths and the
// arbiter FSM state encoding.
package dmem_arbiter_pkg;

  // Data-memory geometry, matching the DATAMEM instance used by SMCore.
  localparam int DATAMEM_ADDR_W = 16;
  localparam int DATAMEM_DATA_W = 16;

  // Arbiter FSM states. A write uses IDLE->ACCESS, a read uses
  // IDLE->ACCESS->RESP.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_select.sv
// Round-robin find-first-set: returns the first set request bit found when
// searching ptr, ptr+1, ... modulo N. Purely combinational so it can be
// reused for warp selection.
module rr_select #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] winner
);

  // Index reached after stepping 'off' places from 'base', wrapping at N.
  function automatic logic [IDX_W-1:0] rot_idx(input logic [IDX_W-1:0] base,
                                               input int off);
    int s;
    s = int'(base) + off;
    if (s >= N) s = s - N;
    return IDX_W'(s);
  endfunction

  // Scan from the farthest offset down to zero so the closest set bit to
  // ptr is the last assignment and therefore wins.
  always_comb begin
    any    = |req;
    winner = '0;
    for (int off = N - 1; off >= 0; off--) begin
      if (req[rot_idx(ptr, off)]) winner = rot_idx(ptr, off);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data memory among N_REQ
// requesters, with a single access in flight at a time.
//
// Handshake (per requester i): req[i] with req_we/req_addr/req_wdata is held
// stable until gnt[i] pulses for one cycle; from the following cycle the
// requester may drop req or present a new request. For a read, rvalid[i]
// pulses for one cycle two cycles after gnt[i], with the word on rdata.
// Requests are only sampled while the FSM is IDLE.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = DATAMEM_ADDR_W,
  parameter int DATA_W = DATAMEM_DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         rvalid,
  output logic [DATA_W-1:0]        rdata,
  output logic                     busy,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic                     mem_we,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [1:0]               state_dbg
);

  localparam int               IDX_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   idx_q;
  logic               we_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;

  logic               any;
  logic [IDX_W-1:0]   winner;

  rr_select #(
    .N     (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req    (req),
    .ptr    (ptr),
    .any    (any),
    .winner (winner)
  );

  // Arbitration FSM: latch the winner in IDLE, run the memory cycle in
  // ACCESS, capture read data in RESP. gnt/rvalid/mem_we are one-cycle
  // pulses, so they default to 0 every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      gnt     <= '0;
      rvalid  <= '0;
      rdata   <= '0;
      busy    <= 1'b0;
      mem_we  <= 1'b0;
    end else begin
      gnt    <= '0;
      rvalid <= '0;
      mem_we <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            idx_q   <= winner;
            we_q    <= req_we[winner];
            addr_q  <= req_addr[winner*ADDR_W +: ADDR_W];
            wdata_q <= req_wdata[winner*DATA_W +: DATA_W];
            gnt     <= ONE_HOT0 << winner;
            mem_we  <= req_we[winner];
            ptr     <= (winner == LAST_IDX) ? '0 : winner + 1'b1;
            busy    <= 1'b1;
            state   <= ACCESS;
          end
        end
        ACCESS: begin
          // A write commits at the end of this cycle; a read needs one more
          // cycle for the synchronous memory to return data.
          if (we_q) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= RESP;
          end
        end
        RESP: begin
          rdata  <= mem_rdata;
          rvalid <= ONE_HOT0 << idx_q;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // The memory port is driven straight from the latched request.
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus randomized traffic,
// checked every cycle against a transaction-level reference model.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int N = 4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT connections ----------------
  logic [N-1:0]    req_drv, we_drv;
  logic [15:0]     addr_drv [N];
  logic [15:0]     data_drv [N];
  logic [N*16-1:0] req_addr, req_wdata;
  logic [N-1:0]    gnt, rvalid;
  logic [15:0]     rdata, mem_addr, mem_wdata, mem_rdata;
  logic            busy, mem_we;
  logic [1:0]      state_dbg;

  always_comb begin
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*16 +: 16]  = addr_drv[i];
      req_wdata[i*16 +: 16] = data_drv[i];
    end
  end

  dmem_arbiter #(.N_REQ(N), .ADDR_W(16), .DATA_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req_drv),
    .req_we    (we_drv),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .state_dbg (state_dbg)
  );

  // Synchronous-read memory the DUT talks to.
  logic [15:0] mem [65536];
  always @(posedge clk) begin
    if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // One access at a time; the model schedules the cycle numbers at which
  // gnt and rvalid must appear and when the arbiter is free again.
  logic [15:0] ref_mem [65536];
  int          cyc = 0;
  int          free_at = 0;
  int          ptr_m = 0;
  int          ev_g_cyc = -1, ev_r_cyc = -1;
  logic [N-1:0] ev_g_vec, ev_r_vec;
  logic        ev_we;
  logic [15:0] ev_rdata;
  logic [15:0] last_addr = 0, last_wdata = 0, rdata_hold = 0;

  // ---------------- requester drivers ----------------
  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
  } txn_t;
  txn_t txq [N][$];
  logic [N-1:0] ack_prev = '0;
  int  force_rst = 0;
  bit  rst_on_resp = 0;
  bit  rand_mode = 0;
  int  gnt_log [$];

  task automatic push(input int i, input logic we, input logic [15:0] a, input logic [15:0] d);
    txn_t t;
    t.we = we; t.addr = a; t.data = d;
    txq[i].push_back(t);
  endtask

  task automatic load(input int i);
    txn_t t;
    t = txq[i].pop_front();
    req_drv[i]  = 1'b1;
    we_drv[i]   = t.we;
    addr_drv[i] = t.addr;
    data_drv[i] = t.data;
  endtask

  task automatic model_reset();
    if (ev_g_cyc > cyc) ev_g_cyc = -1;
    if (ev_r_cyc > cyc) ev_r_cyc = -1;
    free_at    = 0;
    ptr_m      = 0;
    last_addr  = 0;
    last_wdata = 0;
    rdata_hold = 0;
  endtask

  task automatic arbitrate();
    int  w;
    bit  found;
    w = 0; found = 0;
    for (int off = 0; off < N; off++) begin
      if (!found && req_drv[(ptr_m + off) % N]) begin
        w = (ptr_m + off) % N;
        found = 1;
      end
    end
    ev_g_cyc   = cyc + 1;
    ev_g_vec   = N'(1) << w;
    ev_we      = we_drv[w];
    last_addr  = addr_drv[w];
    last_wdata = data_drv[w];
    if (we_drv[w]) begin
      ref_mem[addr_drv[w]] = data_drv[w];
      free_at = cyc + 2;
    end else begin
      ev_r_cyc = cyc + 3;
      ev_r_vec = N'(1) << w;
      ev_rdata = ref_mem[addr_drv[w]];
      free_at  = cyc + 3;
    end
    ptr_m = (w + 1) % N;
  endtask

  // One clock cycle: check outputs, update requesters, then decide reset or
  // arbitration for the edge that ends this cycle.
  task automatic step();
    logic [N-1:0] eg, er;
    logic [1:0]   es;
    bit           rst_now;
    @(posedge clk);
    #1;
    eg = (ev_g_cyc == cyc) ? ev_g_vec : '0;
    er = (ev_r_cyc == cyc) ? ev_r_vec : '0;
    if (ev_r_cyc == cyc) rdata_hold = ev_rdata;
    if (cyc < free_at) es = (cyc == ev_g_cyc) ? 2'(ACCESS) : 2'(RESP);
    else               es = 2'(IDLE);
    check_eq("gnt",       gnt,       eg);
    check_eq("rvalid",    rvalid,    er);
    check_eq("rdata",     rdata,     rdata_hold);
    check_eq("busy",      busy,      cyc < free_at);
    check_eq("mem_we",    mem_we,    (ev_g_cyc == cyc) ? ev_we : 1'b0);
    check_eq("mem_addr",  mem_addr,  last_addr);
    check_eq("mem_wdata", mem_wdata, last_wdata);
    check_eq("state",     state_dbg, es);
    for (int i = 0; i < N; i++) if (gnt[i] === 1'b1) gnt_log.push_back(i);

    // requesters
    for (int i = 0; i < N; i++) begin
      if (rand_mode && txq[i].size() == 0 && $urandom_range(0, 3) == 0)
        push(i, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), 16'($urandom));
      if (ack_prev[i] || !req_drv[i]) begin
        if (txq[i].size() > 0) begin
          load(i);
        end else begin
          req_drv[i]  = 1'b0;
          we_drv[i]   = 1'($urandom_range(0, 1));
          addr_drv[i] = 16'($urandom);
          data_drv[i] = 16'($urandom);
        end
      end
    end
    ack_prev = eg;

    // reset / arbitration decision
    rst_now = 0;
    if (force_rst > 0) begin
      rst_now = 1;
      force_rst--;
    end else if (rst_on_resp && ev_r_cyc == cyc + 1) begin
      rst_now = 1;
      rst_on_resp = 0;
    end else if (rand_mode && $urandom_range(0, 63) == 0) begin
      rst_now = 1;
    end
    reset = rst_now;
    if (rst_now) model_reset();
    else if (cyc >= free_at && req_drv != '0) arbitrate();
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset   = 1'b1;
    req_drv = '0;
    we_drv  = '0;
    for (int i = 0; i < N; i++) begin
      addr_drv[i] = '0;
      data_drv[i] = '0;
    end
    for (int a = 0; a < 65536; a++) begin
      mem[a]     = 16'(a * 40503) ^ 16'h5A5A;
      ref_mem[a] = 16'(a * 40503) ^ 16'h5A5A;
    end
    mem[16'h0010]     = 16'hBEEF;
    ref_mem[16'h0010] = 16'hBEEF;

    // reset
    force_rst = 3;
    run(3);

    // single read by requester 2
    push(2, 1'b0, 16'h0010, 16'h0000);
    run(8);
    check_eq("single_read_data", rdata, 16'hBEEF);

    // write then read-back by requester 1
    push(1, 1'b1, 16'h0020, 16'h1234);
    push(1, 1'b0, 16'h0020, 16'h0000);
    run(10);
    check_eq("raw_data", rdata, 16'h1234);

    // four simultaneous writes right after reset (ptr=0)
    force_rst = 1;
    for (int i = 0; i < N; i++) push(i, 1'b1, 16'(16'h0100 + i), 16'(16'hA000 + i));
    gnt_log.delete();
    run(12);
    for (int i = 0; i < N; i++) begin
      check_eq("sim_wr_order", (gnt_log.size() > i) ? 32'(gnt_log[i]) : 32'hFFFF, i);
      check_eq("sim_wr_mem", mem[16'h0100 + i], 16'(16'hA000 + i));
    end

    // fairness: requesters 0 and 3 stream reads
    for (int j = 0; j < 5; j++) begin
      push(0, 1'b0, 16'(16'h0030 + j), 16'h0000);
      push(3, 1'b0, 16'(16'h0038 + j), 16'h0000);
    end
    gnt_log.delete();
    run(35);
    for (int j = 0; j < 10; j++)
      check_eq("fair_order", (gnt_log.size() > j) ? 32'(gnt_log[j]) : 32'hFFFF, (j % 2 == 0) ? 0 : 3);

    // reset while a read is in RESP; requester 1 must then win over 3
    rst_on_resp = 1;
    push(2, 1'b0, 16'h0010, 16'h0000);
    run(6);
    push(1, 1'b0, 16'h0020, 16'h0000);
    push(3, 1'b0, 16'h0010, 16'h0000);
    gnt_log.delete();
    run(10);
    check_eq("post_rst_first", (gnt_log.size() > 0) ? 32'(gnt_log[0]) : 32'hFFFF, 1);
    check_eq("post_rst_second", (gnt_log.size() > 1) ? 32'(gnt_log[1]) : 32'hFFFF, 3);

    // idle
    run(20);

    // random traffic with occasional resets, then drain
    rand_mode = 1;
    run(800);
    rand_mode = 0;
    run(30);

    for (int a = 0; a < 512; a++) check_eq("final_mem", mem[a], ref_mem[a]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-port, synchronous-read data memory (16-bit address, 16-bit word) among N_REQ requesters.
- Requesters are SMCore instances in the multi-SM build, each running its own per-core memory sequencing upstream.
- Arbitration is round-robin with one access in flight at a time, over a per-requester req/gnt/rvalid handshake.

Parameters:
- N_REQ, 4, number of requesters; must be ≥2.
- ADDR_W, 16, data-memory address width.
- DATA_W, 16, data word width.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  N_REQ  per-requester access request; held until that requester's gnt.
- req_we  in  N_REQ  per-requester write enable; 1=write, 0=read; valid with req.
- req_addr  in  N_REQ*ADDR_W  flattened addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  N_REQ*DATA_W  flattened write data, same packing.
- gnt  out  N_REQ  one-hot, one-cycle pulse: request accepted and memory access in progress.
- rvalid  out  N_REQ  one-hot, one-cycle pulse: read data on rdata belongs to this requester.
- rdata  out  DATA_W  read data, broadcast to all requesters; qualified by rvalid.
- busy  out  1  high whenever state != IDLE.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write strobe.
- mem_rdata  in  DATA_W  memory read data; valid one cycle after mem_addr is presented.

Behaviour:
- Reset values: gnt=0, rvalid=0, rdata=0, busy=0, mem_addr=0, mem_wdata=0, mem_we=0, RR pointer ptr=0, state=IDLE, latched index/we/addr/wdata=0.
- Reset has priority over all other activity.
  - Mid-operation reset abandons the access: no gnt, rvalid or mem_we is issued for it afterwards.
  - If reset is sampled in ACCESS, mem_we is 0 in the following cycle.
- States: IDLE, ACCESS, RESP.
- IDLE, some req bit set:
  - Winner = first set bit searching ptr, ptr+1, … modulo N_REQ.
  - Latch winner index, req_we, req_addr and req_wdata.
  - ptr ← (winner+1) mod N_REQ.
  - Next state ACCESS.
- IDLE, no req: remain in IDLE; all outputs hold, except gnt, rvalid and mem_we, which are 0.
- ACCESS (1 cycle):
  - gnt[winner]=1; mem_addr and mem_wdata driven from the latched values; mem_we = latched we.
  - Write: next state IDLE; the write commits at the end of this cycle.
  - Read: next state RESP.
- RESP (1 cycle):
  - mem_rdata is valid; register it into rdata.
  - Set rvalid[winner] for the next cycle; next state IDLE.
- rvalid/rdata overlap with the next IDLE cycle; new arbitration proceeds in that same cycle.
- rdata holds its value until the next read completes.
- Latency, request sampled in IDLE at cycle t:
  - gnt at t+1.
  - Read: rvalid/rdata at t+3; read throughput is 1 per 3 cycles.
  - Write: done at end of t+1; write throughput is 1 per 2 cycles.
- Requester rule:
  - Keep req/req_we/req_addr/req_wdata stable until the gnt cycle.
  - From the next cycle, drop req or present a new request.
  - Inputs are ignored outside IDLE.
- Read after write to the same address (sequential) returns the new data; writes commit in ACCESS, before any later IDLE sample.
- gnt and rvalid are never asserted for more than one requester, and never in the same cycle for the same access.
- Address/data widths pass through unmodified; no arithmetic beyond the modulo-N_REQ pointer increment, which wraps N_REQ-1 → 0.

Decomposition:
- Shared package holds:
  - the ADDR_W/DATA_W defaults, shared with the existing INSTMEM/DATAMEM width constants;
  - the state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2).
- One sub-module, rr_select: combinational find-first-set from a rotating pointer.
  - Inputs: req vector, ptr.
  - Outputs: any, winner index.
  - Reused later for warp selection.

Test Plan:
- Single read: after reset, req[2]=1, req_addr[2]=0x0010, mem[0x0010]=0xBEEF at t → gnt=4'b0100 at t+1, mem_addr=0x0010, mem_we=0; rvalid=4'b0100 with rdata=0xBEEF at t+3.
- Write then read: req[1] writes 0x1234 to 0x0020 → mem_we=1 at t+1 only. Requester 1 then reads 0x0020 → rdata=0x1234 with rvalid[1].
- Simultaneous writes: all four req_we=1 at cycle 0 with ptr=0 → gnt order 0,1,2,3 at cycles 1,3,5,7; memory holds all four values.
- Fairness: req[0] and req[3] held continuously for reads → grants alternate 0,3,0,3; no requester is granted twice in a row while the other waits.
- Reset mid-read: assert reset during RESP → no rvalid ever appears for that read; outputs at reset values; next request from requester 1 is granted first, because ptr=0 and the search reaches 1.
- Idle: no req for 20 cycles → busy=0, mem_we=0, gnt=0, rvalid=0 throughout.
